// File: rtl/qlf_k4n8_cfg_pkg.sv
// Shared types and sizing helpers for the K4N8 cluster
// configuration-chain loader.
package qlf_k4n8_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_RB_SHIFT,
    ST_RB_OUT,
    ST_FIN
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int chain_len(input int nl, input int lb);
    return nl * lb;
  endfunction

  function automatic int nwords(
    input int nl,
    input int lb,
    input int w
  );
    return (nl * lb) / w;
  endfunction

endpackage

// File: rtl/qlf_k4n8_cfg_tick.sv
// Shift-rate divider: one tick every SHIFT_DIV enabled cycles,
// counted from the last clear.
module qlf_k4n8_cfg_tick
  import qlf_k4n8_cfg_pkg::*;
#(
  parameter int SHIFT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW =
    (clog2(SHIFT_DIV) < 1) ? 1 : clog2(SHIFT_DIV);
  localparam logic [CW-1:0] LAST = CW'(SHIFT_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/qlf_k4n8_cfg_loader.sv
// Serial configuration-chain sequencer for one K4N8 cluster:
// stream write into the chain and non-destructive readback.
module qlf_k4n8_cfg_loader
  import qlf_k4n8_cfg_pkg::*;
#(
  parameter int NUM_LUTS  = 8,
  parameter int LUT_BITS  = 16,
  parameter int WORD_W    = 32,
  parameter int SHIFT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              readback,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              cfg_shift,
  output logic              cfg_sdo,
  input  logic              cfg_sdi,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CL  = chain_len(NUM_LUTS, LUT_BITS);
  localparam int NW  = nwords(NUM_LUTS, LUT_BITS, WORD_W);
  localparam int BCW = clog2(WORD_W + 1);
  localparam int WCW = clog2(NW + 1);

  localparam logic [BCW-1:0] BLAST = BCW'(WORD_W - 1);
  localparam logic [WCW-1:0] WNUM  = WCW'(NW);

  if (CL % WORD_W != 0) begin : g_bad_word_w
    $error("chain length must be a multiple of WORD_W");
  end
  if (SHIFT_DIV < 1) begin : g_bad_div
    $error("SHIFT_DIV must be at least 1");
  end

  state_t            state;
  state_t            state_d;
  logic [WORD_W-1:0] shreg;
  logic [BCW-1:0]    bcnt;
  logic [WCW-1:0]    wcnt;
  logic              aborted_q;
  logic              tick;
  logic              in_shift;
  logic              enter_shift;
  logic              take_abort;
  logic              last_bit;
  logic              more_words;

  assign in_shift = (state == ST_SHIFT)
                 || (state == ST_RB_SHIFT);
  assign take_abort = abort && (state != ST_IDLE);
  assign last_bit = (bcnt == BLAST);
  assign more_words = (wcnt < WNUM);
  assign enter_shift = (state_d != state)
    && ((state_d == ST_SHIFT) || (state_d == ST_RB_SHIFT));

  qlf_k4n8_cfg_tick #(
    .SHIFT_DIV(SHIFT_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (enter_shift || take_abort),
    .en  (in_shift),
    .tick(tick)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = readback ? ST_RB_SHIFT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (s_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick && last_bit) begin
          state_d = more_words ? ST_FETCH : ST_FIN;
        end
      end
      ST_RB_SHIFT: begin
        if (tick && last_bit) state_d = ST_RB_OUT;
      end
      ST_RB_OUT: begin
        if (m_ready) begin
          state_d = more_words ? ST_RB_SHIFT : ST_FIN;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (take_abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      wcnt      <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_d;
      aborted_q <= take_abort;
      if (!take_abort) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              bcnt <= '0;
              wcnt <= '0;
            end
          end
          ST_FETCH: begin
            if (s_valid) begin
              shreg <= s_data;
              wcnt  <= wcnt + WCW'(1);
            end
          end
          ST_SHIFT: begin
            if (tick) begin
              shreg <= shreg >> 1;
              bcnt  <= last_bit ? '0 : bcnt + BCW'(1);
            end
          end
          ST_RB_SHIFT: begin
            if (tick) begin
              shreg <= {cfg_sdi, shreg[WORD_W-1:1]};
              bcnt  <= last_bit ? '0 : bcnt + BCW'(1);
              if (last_bit) wcnt <= wcnt + WCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Readback recirculates the tail bit straight back into the head.
  always_comb begin
    cfg_shift = tick && !abort;
    cfg_sdo   = 1'b0;
    if (cfg_shift) begin
      cfg_sdo = (state == ST_SHIFT) ? shreg[0] : cfg_sdi;
    end
  end

  assign s_ready = (state == ST_FETCH) && !abort;
  assign m_valid = (state == ST_RB_OUT);
  assign m_data  = m_valid ? shreg : '0;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_FIN) && !abort;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_qlf_k4n8_cfg_loader.sv
// Scoreboard bench for the cluster config loader, with a
// behavioural 128-stage chain attached to the DUT.
module tb_qlf_k4n8_cfg_loader;

  localparam int W  = 32;
  localparam int CL = 128;
  localparam int NW = 4;

  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic readback = 0;
  logic abort = 0;
  logic s_valid = 0;
  logic [W-1:0] s_data = '0;
  logic m_ready = 0;
  logic sel = 0;
  logic [CL-1:0] chain = '0;
  logic cfg_sdi;

  logic s_ready1, m_valid1, cfg_shift1, cfg_sdo1;
  logic busy1, done1, aborted1;
  logic [W-1:0] m_data1;
  logic s_ready3, m_valid3, cfg_shift3, cfg_sdo3;
  logic busy3, done3, aborted3;
  logic [W-1:0] m_data3;

  logic s_ready, m_valid, cfg_shift, cfg_sdo;
  logic busy, done, aborted;
  logic [W-1:0] m_data;

  always #5 clk = ~clk;

  assign cfg_sdi = chain[CL-1];

  qlf_k4n8_cfg_loader #(
    .NUM_LUTS(8), .LUT_BITS(16), .WORD_W(W), .SHIFT_DIV(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start && !sel),
    .readback(readback), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .cfg_shift(cfg_shift1), .cfg_sdo(cfg_sdo1),
    .cfg_sdi(cfg_sdi), .busy(busy1), .done(done1),
    .aborted(aborted1)
  );

  qlf_k4n8_cfg_loader #(
    .NUM_LUTS(8), .LUT_BITS(16), .WORD_W(W), .SHIFT_DIV(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .start(start && sel),
    .readback(readback), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data),
    .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3),
    .cfg_shift(cfg_shift3), .cfg_sdo(cfg_sdo3),
    .cfg_sdi(cfg_sdi), .busy(busy3), .done(done3),
    .aborted(aborted3)
  );

  assign s_ready   = sel ? s_ready3   : s_ready1;
  assign m_valid   = sel ? m_valid3   : m_valid1;
  assign m_data    = sel ? m_data3    : m_data1;
  assign cfg_shift = sel ? cfg_shift3 : cfg_shift1;
  assign cfg_sdo   = sel ? cfg_sdo3   : cfg_sdo1;
  assign busy      = sel ? busy3      : busy1;
  assign done      = sel ? done3      : done1;
  assign aborted   = sel ? aborted3   : aborted1;

  // Physical chain: head is stage 0, tail (stage CL-1) feeds cfg_sdi.
  always @(posedge clk) begin
    if (cfg_shift) chain <= {chain[CL-2:0], cfg_sdo};
  end

  int n_chk = 0;
  int n_fail = 0;
  bit exp_sdo[$];
  logic [W-1:0] exp_word[$];
  logic [W-1:0] cur[NW];
  int done_cnt = 0;
  int abort_cnt = 0;
  int op_shifts = 0;
  int cyc = 0;
  int last_shift = 0;

  task automatic check(input string name,
                       input logic [CL-1:0] act,
                       input logic [CL-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected chain after writing cur[]: stream bit k -> stage CL-1-k.
  function automatic logic [CL-1:0] ref_chain();
    logic [CL-1:0] r;
    for (int k = 0; k < CL; k++) r[CL-1-k] = cur[k / W][k % W];
    return r;
  endfunction

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] stall_d;
    bit stall_v;
    logic [W-1:0] ew;
    bit eb;
    stall_v = 0;
    stall_d = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (s_ready) check("no_shift_in_fetch", CL'(cfg_shift), '0);
      if (cfg_shift) begin
        if (exp_sdo.size() == 0) begin
          check("sdo_unexpected", CL'(exp_sdo.size()), CL'(1));
        end else begin
          eb = exp_sdo.pop_front();
          check("cfg_sdo", CL'(cfg_sdo), CL'(eb));
        end
        if (sel && (op_shifts % W) != 0) begin
          check("div3_spacing", CL'(cyc - last_shift), CL'(3));
        end
        last_shift = cyc;
        op_shifts++;
      end
      if (m_valid && m_ready) begin
        stall_v = 0;
        if (exp_word.size() == 0) begin
          check("word_unexpected", CL'(exp_word.size()), CL'(1));
        end else begin
          ew = exp_word.pop_front();
          check("m_data", CL'(m_data), CL'(ew));
        end
      end else if (m_valid) begin
        if (stall_v) check("m_data_stable", CL'(m_data), CL'(stall_d));
        stall_d = m_data;
        stall_v = 1;
      end else begin
        stall_v = 0;
      end
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
    end
  end

  task automatic tick_in();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic rb);
    tick_in();
    start = 1;
    readback = rb;
    tick_in();
    start = 0;
    readback = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit keep);
    bit ok;
    ok = 0;
    s_data = w;
    s_valid = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    tick_in();
    if (!keep) s_valid = 0;
    check("s_handshake_seen", CL'(ok), CL'(1));
  endtask

  task automatic wait_done(input int base, input string name);
    int c;
    c = 0;
    while (done_cnt == base && c < 2000) begin
      tick_in();
      c++;
    end
    repeat (3) tick_in();
    check(name, CL'(done_cnt - base), CL'(1));
  endtask

  task automatic push_stream();
    logic [CL-1:0] r;
    r = ref_chain();
    for (int n = 0; n < CL; n++) exp_sdo.push_back(r[CL-1-n]);
  endtask

  task automatic write_op(input int gap, input bit busy_start,
                          input string name);
    int base;
    int sbase;
    base = done_cnt;
    sbase = op_shifts;
    push_stream();
    pulse_start(0);
    for (int i = 0; i < NW; i++) begin
      if (gap > 0) repeat (gap) tick_in();
      send_word(cur[i], gap == 0 && i < NW - 1);
      if (busy_start && i == 1) begin
        start = 1;
        readback = 1;
        tick_in();
        start = 0;
        readback = 0;
      end
    end
    wait_done(base, {name, "_done"});
    check({name, "_shifts"}, CL'(op_shifts - sbase), CL'(CL));
    check({name, "_chain"}, chain, ref_chain());
    check({name, "_busy_low"}, CL'(busy), '0);
    check({name, "_sdo_drained"}, CL'(exp_sdo.size()), '0);
  endtask

  task automatic read_op(input string name);
    int base;
    int i;
    int stall;
    int c;
    logic [CL-1:0] r;
    base = done_cnt;
    r = ref_chain();
    push_stream();
    for (int k = 0; k < NW; k++) begin
      logic [W-1:0] w;
      for (int b = 0; b < W; b++) w[b] = r[CL-1-(k*W+b)];
      exp_word.push_back(w);
    end
    pulse_start(1);
    i = 0;
    stall = 0;
    c = 0;
    while (i < NW && c < 3000) begin
      tick_in();
      c++;
      if (m_ready) begin
        i++;
        m_ready = 0;
      end
      if (i < NW && m_valid) begin
        if (i == 2 && stall < 3) stall++;
        else m_ready = 1;
      end
    end
    check({name, "_words"}, CL'(i), CL'(NW));
    wait_done(base, {name, "_done"});
    check({name, "_chain_kept"}, chain, r);
    check({name, "_word_drained"}, CL'(exp_word.size()), '0);
  endtask

  initial begin
    int dbase;
    int sbase;
    int c;
    repeat (3) tick_in();
    rst = 0;
    tick_in();
    check("rst_s_ready", CL'(s_ready), '0);
    check("rst_m_valid", CL'(m_valid), '0);
    check("rst_m_data", CL'(m_data), '0);
    check("rst_cfg_shift", CL'(cfg_shift), '0);
    check("rst_cfg_sdo", CL'(cfg_sdo), '0);
    check("rst_busy", CL'(busy), '0);
    check("rst_done", CL'(done), '0);
    check("rst_aborted", CL'(aborted), '0);

    // abort while idle is ignored
    abort = 1;
    tick_in();
    abort = 0;
    tick_in();
    check("idle_abort_ignored", CL'(abort_cnt), '0);

    cur[0] = 32'h0000FFFF;
    cur[1] = 32'hA5A5A5A5;
    cur[2] = 32'h00000001;
    cur[3] = 32'h80000000;
    write_op(0, 1, "wr_basic");
    check("stage127", CL'(chain[CL-1]), CL'(1));

    write_op(5, 0, "wr_gaps");
    read_op("rb_stall");

    sel = 1;
    tick_in();
    for (int i = 0; i < NW; i++) cur[i] = $urandom;
    write_op(0, 0, "wr_div3");
    read_op("rb_div3");
    sel = 0;
    tick_in();

    // abort after 40 shifts
    for (int i = 0; i < NW; i++) cur[i] = $urandom;
    dbase = done_cnt;
    sbase = op_shifts;
    push_stream();
    pulse_start(0);
    send_word(cur[0], 1);
    send_word(cur[1], 1);
    s_data = cur[2];
    c = 0;
    while (op_shifts - sbase < 40 && c < 500) begin
      tick_in();
      c++;
    end
    abort = 1;
    #1;
    check("abort_cfg_shift", CL'(cfg_shift), '0);
    check("abort_s_ready", CL'(s_ready), '0);
    check("abort_busy", CL'(busy), CL'(1));
    tick_in();
    abort = 0;
    s_valid = 0;
    check("aborted_pulse", CL'(aborted), CL'(1));
    check("abort_idle", CL'(busy), '0);
    check("abort_shifts", CL'(op_shifts - sbase), CL'(40));
    tick_in();
    check("aborted_one_cycle", CL'(aborted), '0);
    repeat (3) tick_in();
    check("abort_no_done", CL'(done_cnt - dbase), '0);
    exp_sdo.delete();
    for (int i = 0; i < NW; i++) cur[i] = $urandom;
    write_op(0, 0, "wr_after_abort");

    // reset while a readback word is waiting
    dbase = done_cnt;
    push_stream();
    pulse_start(1);
    c = 0;
    while (!m_valid && c < 500) begin
      tick_in();
      c++;
    end
    check("rb_out_reached", CL'(m_valid), CL'(1));
    rst = 1;
    tick_in();
    rst = 0;
    check("rst_mid_busy", CL'(busy), '0);
    check("rst_mid_m_valid", CL'(m_valid), '0);
    check("rst_mid_m_data", CL'(m_data), '0);
    check("rst_mid_cfg_shift", CL'(cfg_shift), '0);
    repeat (4) tick_in();
    check("rst_mid_no_done", CL'(done_cnt - dbase), '0);
    check("rst_mid_no_abort", CL'(abort_cnt), CL'(1));
    exp_sdo.delete();
    exp_word.delete();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
